// File: rtl/reset_sequencer.sv
// Staged reset sequencer: merges power-on, debounced push-button and software reset requests,
// releases peripherals first, then the CPU. Optional cause register under RESET_SEQ_CAUSE_EN.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_GAP       = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  input  logic       sw_rst_i,
  output logic       rst_periph_o,
  output logic       rst_cpu_o,
`ifdef RESET_SEQ_CAUSE_EN
  output logic [2:0] rst_cause_o,
`endif
  output logic       rst_done_o
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);
  localparam logic [DebW-1:0] DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StAssert, StPeriph, StRun} state_e;

  // Reset release synchronizer: asserts with rst_ni, releases after SYNC_STAGES edges.
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_rel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_rel = rst_sync_q[SYNC_STAGES-1];

  // Button synchronizer and debouncer.
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [DebW-1:0]        deb_cnt_q;
  logic                   btn_stable_q;
  logic                   btn_req_q;
  logic                   btn_synced;

  assign btn_synced = btn_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_sync_q   <= '0;
      deb_cnt_q    <= '0;
      btn_stable_q <= 1'b0;
      btn_req_q    <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_i};
      btn_req_q  <= 1'b0;
      if (btn_synced != btn_stable_q) begin
        if (deb_cnt_q == DebLast) begin
          btn_stable_q <= btn_synced;
          deb_cnt_q    <= '0;
          // Only a press requests a reset; a release is silently accepted.
          btn_req_q    <= btn_synced;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  logic req;
  assign req = btn_req_q | sw_rst_i;

  // Sequencing FSM with registered outputs.
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            periph_q;
  logic            cpu_q;
  logic            done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StAssert;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      done_q   <= 1'b0;
    end else if (!rst_rel || req) begin
      // Requests win over a same-cycle count completion.
      state_q  <= StAssert;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            state_q  <= StPeriph;
            cnt_q    <= '0;
            periph_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPeriph: begin
          if (cnt_q == GapLast) begin
            state_q <= StRun;
            cnt_q   <= '0;
            cpu_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          cnt_q <= '0;
        end
        default: begin
          state_q  <= StAssert;
          cnt_q    <= '0;
          periph_q <= 1'b1;
          cpu_q    <= 1'b1;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_periph_o = periph_q;
  assign rst_cpu_o    = cpu_q;
  assign rst_done_o   = done_q;

`ifdef RESET_SEQ_CAUSE_EN
  logic [2:0] cause_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q <= 3'b001;
    end else if (rst_rel && req) begin
      cause_q <= {sw_rst_i, btn_req_q, 1'b0};
    end
  end

  assign rst_cause_o = cause_q;
`endif

endmodule
